// File: rtl/branch_predict_unit_pkg.sv
// Shared opcode constants and 2-bit branch-history counter encodings
// for the branch prediction unit.
package branch_predict_unit_pkg;

  localparam logic [4:0] OPC_BRANCH = 5'b11000;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bht_cnt_e;

  function automatic logic is_branch_op(input logic [31:0] inst);
    return inst[6:2] == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module branch_predict_unit_sat_counter2
  import branch_predict_unit_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] nxt_o
);

  always_comb begin
    nxt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != STRONG_T) nxt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != STRONG_NT) nxt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage branch predictor: PC-indexed BHT lookup, prediction carried F->D->E/M,
// resolution against the E/M outcome, counter training and performance counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int          IDX_W    = 4,
  parameter logic [1:0]  CNT_INIT = 2'b01,
  parameter int          PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       f_pc,
  input  logic [31:0]       f_inst,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       e_m_pc,
  input  logic              e_m_is_branch,
  input  logic              e_m_branch_taken,
  output logic              branch_predict,
  output logic              e_m_hit,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]        bht_q [ENTRIES];
  logic [1:0]        bht_d [ENTRIES];
  logic [IDX_W-1:0]  f_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic [1:0]        upd_nxt;
  logic              upd_en;
  logic              pred_fd_q, pred_fd_d;
  logic              pred_de_q, pred_de_d;
  logic [PERF_W-1:0] perf_br_q, perf_br_d;
  logic [PERF_W-1:0] perf_mis_q, perf_mis_d;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^{f_pc[31:IDX_W+2], f_pc[1:0], e_m_pc[31:IDX_W+2], e_m_pc[1:0],
                            f_inst[31:7], f_inst[1:0]};

  // F stage: lookup returns the stored value, never the same-cycle update
  assign f_idx          = f_pc[IDX_W+1:2];
  assign branch_predict = is_branch_op(f_inst) & bht_q[f_idx][1];

  // E/M stage: resolution and training
  assign upd_idx = e_m_pc[IDX_W+1:2];
  assign upd_en  = e_m_is_branch & ~stall;
  assign e_m_hit = ~e_m_is_branch | (pred_de_q == e_m_branch_taken);

  branch_predict_unit_sat_counter2 u_sat (
    .cnt_i   (bht_q[upd_idx]),
    .taken_i (e_m_branch_taken),
    .nxt_o   (upd_nxt)
  );

  always_comb begin
    bht_d = bht_q;
    if (upd_en) bht_d[upd_idx] = upd_nxt;
  end

  always_comb begin
    pred_fd_d  = pred_fd_q;
    pred_de_d  = pred_de_q;
    if (flush) begin
      pred_fd_d = 1'b0;
      pred_de_d = 1'b0;
    end else if (!stall) begin
      pred_fd_d = branch_predict;
      pred_de_d = pred_fd_q;
    end
    perf_br_d  = perf_br_q + {{(PERF_W-1){1'b0}}, upd_en};
    perf_mis_d = perf_mis_q + {{(PERF_W-1){1'b0}}, upd_en & ~e_m_hit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CNT_INIT;
    end else begin
      bht_q <= bht_d;
    end
  end

  // F->D and D->E/M prediction registers, plus counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_fd_q  <= 1'b0;
      pred_de_q  <= 1'b0;
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      pred_fd_q  <= pred_fd_d;
      pred_de_q  <= pred_de_d;
      perf_br_q  <= perf_br_d;
      perf_mis_q <= perf_mis_d;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Vector-table bench for branch_predict_unit with an expected-value scoreboard queue.
module tb_branch_predict_unit;

  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] ADDI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] f_pc = '0, f_inst = '0, e_m_pc = '0;
  logic        stall = 1'b0, flush = 1'b0, e_m_is_branch = 1'b0, e_m_branch_taken = 1'b0;
  logic        branch_predict, e_m_hit;
  logic [31:0] perf_branches, perf_mispredicts;

  branch_predict_unit #(.IDX_W(4), .CNT_INIT(2'b01), .PERF_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .f_pc             (f_pc),
    .f_inst           (f_inst),
    .stall            (stall),
    .flush            (flush),
    .e_m_pc           (e_m_pc),
    .e_m_is_branch    (e_m_is_branch),
    .e_m_branch_taken (e_m_branch_taken),
    .branch_predict   (branch_predict),
    .e_m_hit          (e_m_hit),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, flush;
    logic [31:0] f_pc, f_inst, e_m_pc;
    logic        br, tk;
    logic        exp_bp, exp_hit;
    logic [31:0] exp_nbr, exp_nmis;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp  = 0;
  int   n_miss = 0;

  task automatic add(input logic r, input logic s, input logic fl,
                     input logic [31:0] fpc, input logic [31:0] fin, input logic [31:0] epc,
                     input logic br, input logic tk, input logic bp, input logic hit,
                     input logic [31:0] nbr, input logic [31:0] nmis, input string nm);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = fl;
    v.f_pc = fpc; v.f_inst = fin; v.e_m_pc = epc; v.br = br; v.tk = tk;
    v.exp_bp = bp; v.exp_hit = hit; v.exp_nbr = nbr; v.exp_nmis = nmis; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state: weakly not-taken everywhere, pipe empty
    add(1,0,0, 32'h40, BEQ,  32'h40, 1,1, 0,0, 0,0, "rst_taken_hit");
    add(1,0,0, 32'h40, BEQ,  32'h40, 1,0, 0,1, 0,0, "rst_nt_hit");
    add(1,0,0, 32'h44, ADDI, 32'h0,  0,0, 0,1, 0,0, "rst_nonbranch");
    for (int i = 0; i < 16; i++)
      add(0,0,0, 32'(i*4), BEQ, 32'h0, 0,0, 0,1, 0,0, "sweep_entry");
    // Training up to saturation, then a carried mispredict
    add(0,0,0, 32'h40, BEQ,  32'h40, 1,1, 0,0, 0,0, "train_t1");
    add(0,0,0, 32'h40, BEQ,  32'h40, 1,1, 1,0, 1,1, "train_t2");
    add(0,0,0, 32'h44, ADDI, 32'h0,  0,0, 0,1, 2,2, "train_gap");
    add(0,0,0, 32'h40, BEQ,  32'h40, 1,1, 1,1, 2,2, "train_sat");
    add(0,0,0, 32'h40, BEQ,  32'h40, 1,0, 1,1, 3,2, "dec_from_sat");
    add(0,0,0, 32'h40, BEQ,  32'h40, 1,0, 1,0, 4,2, "carried_mispred");
    add(0,0,0, 32'h40, BEQ,  32'h0,  0,0, 0,1, 5,3, "after_mispred");
    // Stall holds pipe, BHT and counters
    add(0,1,0, 32'h40, BEQ,  32'h40, 1,1, 0,1, 5,3, "stall1");
    add(0,1,0, 32'h40, BEQ,  32'h40, 1,1, 0,1, 5,3, "stall2");
    add(0,1,0, 32'h40, BEQ,  32'h40, 1,1, 0,1, 5,3, "stall3");
    add(0,0,0, 32'h40, BEQ,  32'h40, 1,1, 0,1, 5,3, "stall_release");
    add(0,0,0, 32'h40, BEQ,  32'h0,  0,0, 1,1, 6,3, "post_stall_pred");
    add(0,0,0, 32'h40, BEQ,  32'h0,  0,0, 1,1, 6,3, "fill_pipe");
    // Flush together with stall clears both slots; flushing branch still trains
    add(0,1,1, 32'h40, BEQ,  32'h0,  0,0, 1,1, 6,3, "flush_stall");
    add(0,0,1, 32'h44, ADDI, 32'h40, 1,0, 0,1, 6,3, "de_cleared");
    add(0,0,0, 32'h44, ADDI, 32'h40, 1,0, 0,1, 7,3, "fd_cleared");
    add(0,0,0, 32'h44, ADDI, 32'h40, 1,0, 0,1, 8,3, "nt_sat_low");
    add(0,0,0, 32'h40, BEQ,  32'h0,  0,0, 0,1, 9,3, "low_sat_read");
    add(0,0,0, 32'h40, BEQ,  32'h40, 1,1, 0,0, 9,3, "up_from_zero");
    add(0,0,0, 32'h40, BEQ,  32'h0,  0,0, 0,1, 10,4, "still_weak_nt");
    // Same-index lookup/update, then reset mid-sequence
    add(1,0,0, 32'h80, BEQ,  32'h0,  0,0, 0,1, 0,0, "rst_again");
    add(0,0,0, 32'h80, BEQ,  32'h80, 1,1, 0,0, 0,0, "same_idx_pre");
    add(0,0,0, 32'h80, BEQ,  32'h0,  0,0, 1,1, 1,1, "same_idx_post");
    add(0,0,0, 32'h80, BEQ,  32'h0,  0,0, 1,1, 1,1, "fill_again");
    add(1,0,0, 32'h80, BEQ,  32'h80, 1,0, 0,1, 0,0, "rst_mid_seq");
    add(0,0,0, 32'h80, BEQ,  32'h0,  0,0, 0,1, 0,0, "after_rst");

    foreach (vecs[k]) begin
      @(posedge clk); #1;
      rst = vecs[k].rst; stall = vecs[k].stall; flush = vecs[k].flush;
      f_pc = vecs[k].f_pc; f_inst = vecs[k].f_inst; e_m_pc = vecs[k].e_m_pc;
      e_m_is_branch = vecs[k].br; e_m_branch_taken = vecs[k].tk;
      exp_q.push_back(vecs[k]);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk({e.name, ".branch_predict"}, 32'(branch_predict), 32'(e.exp_bp));
        chk({e.name, ".e_m_hit"},        32'(e_m_hit),        32'(e.exp_hit));
        chk({e.name, ".perf_branches"},  perf_branches,       e.exp_nbr);
        chk({e.name, ".perf_mispred"},   perf_mispredicts,    e.exp_nmis);
      end
    end

    // Asynchronous reset in the low clock phase, away from any edge
    @(posedge clk); #1;
    f_pc = 32'h80; f_inst = BEQ; e_m_pc = 32'h80; e_m_is_branch = 1'b1; e_m_branch_taken = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("pre_async.branch_predict", 32'(branch_predict), 32'd1);
    chk("pre_async.perf_branches",  perf_branches,       32'd2);
    chk("pre_async.perf_mispred",   perf_mispredicts,    32'd2);
    #1 rst = 1'b1;
    #1;
    chk("async_rst.branch_predict", 32'(branch_predict), 32'd0);
    chk("async_rst.e_m_hit",        32'(e_m_hit),        32'd0);
    chk("async_rst.perf_branches",  perf_branches,       32'd0);
    chk("async_rst.perf_mispred",   perf_mispredicts,    32'd0);
    @(posedge clk); #1 rst = 1'b0; e_m_is_branch = 1'b0;
    @(negedge clk);
    chk("post_async.branch_predict", 32'(branch_predict), 32'd0);
    chk("post_async.perf_branches",  perf_branches,       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
